// File: rtl/simd_alu_decoder.sv
// Secondary ALU decoder: maps Opcode/Func and the main decoder's ALUOp hint to a
// registered ALUControl code, plus vector-op and illegal-encoding flags.
module simd_alu_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [2:0] Func,
    input  logic       ALUOp,
    output logic [2:0] ALUControl,
    output logic       IsVector,
    output logic       Illegal
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CTL_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_VRTYPE = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SUBI   = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_MULI   = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI    = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_XORI   = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE    = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_LW     = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW     = OP_W'(6'b101011);

    localparam logic [CTL_W-1:0] ALU_ADD = CTL_W'(3'b000);
    localparam logic [CTL_W-1:0] ALU_SUB = CTL_W'(3'b001);
    localparam logic [CTL_W-1:0] ALU_MUL = CTL_W'(3'b010);
    localparam logic [CTL_W-1:0] ALU_AND = CTL_W'(3'b011);
    localparam logic [CTL_W-1:0] ALU_OR  = CTL_W'(3'b100);
    localparam logic [CTL_W-1:0] ALU_XOR = CTL_W'(3'b101);

    logic [CTL_W-1:0] ctl_c;
    logic             vec_c;
    logic             ill_c;

    // Func is only consulted on the two R-type opcodes, so it never leaks otherwise
    always_comb begin
        ctl_c = ALU_ADD;
        vec_c = 1'b0;
        ill_c = 1'b0;
        if (ALUOp) begin
            case (Opcode)
                OP_RTYPE:  ctl_c = Func;
                OP_VRTYPE: begin
                    ctl_c = Func;
                    vec_c = 1'b1;
                end
                OP_ADDI:   ctl_c = ALU_ADD;
                OP_SUBI:   ctl_c = ALU_SUB;
                OP_MULI:   ctl_c = ALU_MUL;
                OP_ANDI:   ctl_c = ALU_AND;
                OP_ORI:    ctl_c = ALU_OR;
                OP_XORI:   ctl_c = ALU_XOR;
                OP_BEQ,
                OP_BNE:    ctl_c = ALU_SUB;
                OP_LW,
                OP_SW:     ctl_c = ALU_ADD;
                default:   ill_c = 1'b1;
            endcase
        end
    end

    // Decode/execute boundary register; reset wins over that cycle's decode
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUControl <= ALU_ADD;
            IsVector   <= 1'b0;
            Illegal    <= 1'b0;
        end else begin
            ALUControl <= ctl_c;
            IsVector   <= vec_c;
            Illegal    <= ill_c;
        end
    end

endmodule

// File: tb/tb_simd_alu_decoder.sv
// Bench for simd_alu_decoder: directed vector table, reset corner sequence and a
// random sweep, all checked one cycle later through an expected-result queue.
module tb_simd_alu_decoder;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic [2:0] Func;
    logic       ALUOp;
    logic [2:0] ALUControl;
    logic       IsVector;
    logic       Illegal;

    simd_alu_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .Func       (Func),
        .ALUOp      (ALUOp),
        .ALUControl (ALUControl),
        .IsVector   (IsVector),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ctl;
        logic       vec;
        logic       ill;
    } exp_t;

    typedef struct {
        logic       r;
        logic       a;
        logic [5:0] op;
        logic [2:0] fn;
        logic       fn_dc;
        exp_t       e;
    } vec_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Compare the registered outputs against the oldest outstanding expectation
    task automatic check_out();
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if ({ALUControl, IsVector, Illegal} !== {e.ctl, e.vec, e.ill}) begin
                n_bad++;
                $display("FAIL %s: got ctl=%b vec=%b ill=%b, want ctl=%b vec=%b ill=%b",
                         t, ALUControl, IsVector, Illegal, e.ctl, e.vec, e.ill);
            end
        end
    endtask

    task automatic step(input logic r, input logic a, input logic [5:0] op,
                        input logic [2:0] fn, input exp_t e, input string tag);
        @(negedge clk);
        check_out();
        rst    = r;
        ALUOp  = a;
        Opcode = op;
        Func   = fn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Reference decode written as a lookup over the immediate/branch/memory opcodes
    function automatic exp_t model(input logic r, input logic a,
                                   input logic [5:0] op, input logic [2:0] fn);
        logic [5:0] ops [10] = '{6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
                                 6'b001110, 6'b000100, 6'b000101, 6'b100011, 6'b101011};
        logic [2:0] cds [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd0, 3'd0};
        exp_t e;
        e = '0;
        if (r || !a) return e;
        if (op == 6'b000000) return '{ctl: fn, vec: 1'b0, ill: 1'b0};
        if (op == 6'b100000) return '{ctl: fn, vec: 1'b1, ill: 1'b0};
        for (int k = 0; k < 10; k++)
            if (ops[k] == op) return '{ctl: cds[k], vec: 1'b0, ill: 1'b0};
        e.ill = 1'b1;
        return e;
    endfunction

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic [5:0] op,
                       input logic [2:0] fn, input logic dc,
                       input logic [2:0] ctl, input logic v, input logic il);
        vec_t x;
        x.r = r; x.a = a; x.op = op; x.fn = fn; x.fn_dc = dc;
        x.e = '{ctl: ctl, vec: v, ill: il};
        vecs.push_back(x);
    endtask

    initial begin
        logic [2:0] fn;
        logic [5:0] op;
        logic       a;
        logic       r;
        logic [5:0] pick [12] = '{6'b000000, 6'b100000, 6'b001000, 6'b001001, 6'b001010,
                                  6'b001100, 6'b001101, 6'b001110, 6'b000100, 6'b000101,
                                  6'b100011, 6'b101011};

        rst = 1'b1; ALUOp = 1'b0; Opcode = '0; Func = '0;

        //    rst   aluop op         func  dc    ctl   vec   ill
        add(1'b1, 1'b1, 6'b111111, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b000000, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b000000, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b000000, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b100000, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 6'b100000, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 6'b100000, 3'd6, 1'b0, 3'd6, 1'b1, 1'b0);
        add(1'b0, 1'b1, 6'b001000, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b001001, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b001010, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b001100, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b001101, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b001110, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b000100, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b000101, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b100011, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b101011, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 6'b000000, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 6'b100000, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 6'b111111, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 6'b001011, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 6'b100001, 3'd3, 1'b0, 3'd0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            fn = vecs[i].fn_dc ? 3'($urandom_range(7, 0)) : vecs[i].fn;
            step(vecs[i].r, vecs[i].a, vecs[i].op, fn, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Reset lands mid-stream on an illegal op, then decode resumes on the next edge
        step(1'b0, 1'b1, 6'b100000, 3'd4, '{ctl: 3'd4, vec: 1'b1, ill: 1'b0}, "pre_rst_vec");
        step(1'b1, 1'b1, 6'b111111, 3'd4, '{ctl: 3'd0, vec: 1'b0, ill: 1'b0}, "rst_over_illegal");
        step(1'b1, 1'b1, 6'b100000, 3'd7, '{ctl: 3'd0, vec: 1'b0, ill: 1'b0}, "rst_over_vec");
        step(1'b0, 1'b1, 6'b001110, 3'd2, '{ctl: 3'd5, vec: 1'b0, ill: 1'b0}, "post_rst_xori");
        step(1'b0, 1'b1, 6'b111111, 3'd2, '{ctl: 3'd0, vec: 1'b0, ill: 1'b1}, "illegal_after");
        step(1'b0, 1'b0, 6'b111111, 3'd2, '{ctl: 3'd0, vec: 1'b0, ill: 1'b0}, "aluop0_clears");

        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(3, 0) == 0) ? 6'($urandom_range(63, 0))
                                             : pick[$urandom_range(11, 0)];
            fn = 3'($urandom_range(7, 0));
            a  = ($urandom_range(7, 0) != 0);
            r  = ($urandom_range(19, 0) == 0);
            step(r, a, op, fn, model(r, a, op, fn), $sformatf("rand%0d", i));
        end

        @(negedge clk);
        check_out();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
